// File: rtl/idu_pkg.sv
// Instruction decode unit package: field widths, opcode constants, source selects, decode payload.
package idu_pkg;

    localparam int unsigned INSTR_W  = 8;
    localparam int unsigned REG_EN_W = 9;
    localparam int unsigned SRC_W    = 4;
    localparam int unsigned NOP_W    = 4;
    localparam int unsigned REG_W    = 3;

    // Opcode field constants
    localparam logic [1:0] OP_MOVE = 2'b10;   // ir[7:6]
    localparam logic [2:0] OP_RO   = 3'b110;  // ir[7:5]
    localparam logic [3:0] OP_JMP  = 4'hE;    // ir[7:4]
    localparam logic [3:0] OP_JNZ  = 4'hF;    // ir[7:4]

    // Register numbers with special handling
    localparam logic [REG_W-1:0] REG_O = 3'd4;
    localparam logic [REG_W-1:0] REG_I = 3'd6;
    localparam logic [REG_W-1:0] REG_7 = 3'd7;

    // reg_en bit positions
    localparam int unsigned REG_O_IDX  = 8;
    localparam int unsigned REG_RO_IDX = 4;
    localparam int unsigned REG_I_IDX  = 6;

    // Source selects beyond the plain register numbers
    localparam logic [SRC_W-1:0] SRC_PM    = 4'd8;
    localparam logic [SRC_W-1:0] SRC_IPINS = 4'd9;
    localparam logic [SRC_W-1:0] SRC_NONE  = 4'd10;
    localparam logic [SRC_W-1:0] SRC_O     = 4'd4;

    // NOP opcodes, in nop_hit bit order
    localparam logic [INSTR_W-1:0] NOP_C8 = 8'hC8;
    localparam logic [INSTR_W-1:0] NOP_CF = 8'hCF;
    localparam logic [INSTR_W-1:0] NOP_D8 = 8'hD8;
    localparam logic [INSTR_W-1:0] NOP_DF = 8'hDF;

    typedef struct packed {
        logic [REG_EN_W-1:0] reg_en;
        logic [SRC_W-1:0]    source_sel;
        logic                i_sel;
        logic                jmp;
        logic                jmp_nz;
        logic [NOP_W-1:0]    nop_hit;
    } dec_out_t;

    localparam dec_out_t DEC_IDLE = '{
        reg_en:     '0,
        source_sel: SRC_NONE,
        i_sel:      1'b1,
        jmp:        1'b0,
        jmp_nz:     1'b0,
        nop_hit:    '0
    };

endpackage

// File: rtl/idu_fifo.sv
// Prefetch queue: power-of-two depth, flush empties it and drops a same-cycle push.
module idu_fifo
    import idu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign dout    = mem[rd_ptr];

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      level <= level + LVL_W'(1);
            else if (do_pop && !do_push) level <= level - LVL_W'(1);
        end
    end

    // Storage; contents are only observed while the queue is non-empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_decode_unit.sv
// Instruction decode unit: prefetch queue, decode register and combinational field decode.
// Optional NOP counter enabled by defining IDU_NOP_CNT_EN.
module instr_decode_unit
    import idu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [INSTR_W-1:0]        instr_in,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    output logic                      dec_valid,
    input  logic                      dec_ready,
    input  logic                      flush,
    output logic [INSTR_W-1:0]        ir,
    output logic [3:0]                ir_nibble,
    output logic [REG_EN_W-1:0]       reg_en,
    output logic [SRC_W-1:0]          source_sel,
    output logic                      i_sel,
    output logic                      x_sel,
    output logic                      y_sel,
    output logic                      jmp,
    output logic                      jmp_nz,
    output logic [NOP_W-1:0]          nop_hit,
    output logic [$clog2(DEPTH):0]    q_level
`ifdef IDU_NOP_CNT_EN
    ,
    output logic [CNT_W-1:0]          nop_count
`endif
);

    // Reject unsupported configurations at elaboration
    if (CNT_W == 0 || DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
        $error("instr_decode_unit: unsupported DEPTH/CNT_W");
    end

    logic [INSTR_W-1:0] q_head;
    logic               q_full;
    logic               q_empty;
    logic               load_dec;
    logic               is_load;
    logic               is_move;
    logic [REG_W-1:0]   dest;
    logic [REG_W-1:0]   src;
    dec_out_t           dec;

    assign instr_ready = ~q_full;
    assign load_dec    = ~q_empty & (~dec_valid | dec_ready);

    idu_fifo #(
        .DEPTH (DEPTH),
        .W     (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (instr_valid),
        .pop     (load_dec),
        .flush   (flush),
        .din     (instr_in),
        .dout    (q_head),
        .full    (q_full),
        .empty   (q_empty),
        .level   (q_level)
    );

    // Decode register: refill from queue head when empty or being consumed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dec_valid <= 1'b0;
            ir        <= '0;
        end else if (flush) begin
            dec_valid <= 1'b0;
        end else if (load_dec) begin
            dec_valid <= 1'b1;
            ir        <= q_head;
        end else if (dec_ready) begin
            dec_valid <= 1'b0;
        end
    end

    assign is_load = ~ir[7];
    assign is_move = (ir[7:6] == OP_MOVE);
    assign dest    = is_load ? ir[6:4] : ir[5:3];
    assign src     = ir[2:0];

    // Field decode of the registered instruction, idle when nothing is presented
    always_comb begin
        dec = DEC_IDLE;
        if (dec_valid) begin
            if (is_load || is_move) begin
                if (dest == REG_O) dec.reg_en[REG_O_IDX] = 1'b1;
                else               dec.reg_en[4'(dest)]  = 1'b1;
                if (dest == REG_7 || (is_move && src == REG_7)) dec.reg_en[REG_I_IDX] = 1'b1;
                if (dest == REG_I) dec.i_sel = 1'b0;
                if (is_load)                            dec.source_sel = SRC_PM;
                else if (dest != src)                   dec.source_sel = SRC_W'(src);
                else if (dest == REG_O)                 dec.source_sel = SRC_O;
                else                                    dec.source_sel = SRC_IPINS;
            end
            if (ir[7:5] == OP_RO) dec.reg_en[REG_RO_IDX] = 1'b1;
            dec.jmp     = (ir[7:4] == OP_JMP);
            dec.jmp_nz  = (ir[7:4] == OP_JNZ);
            dec.nop_hit = {ir == NOP_DF, ir == NOP_D8, ir == NOP_CF, ir == NOP_C8};
        end
    end

    assign reg_en     = dec.reg_en;
    assign source_sel = dec.source_sel;
    assign i_sel      = dec.i_sel;
    assign jmp        = dec.jmp;
    assign jmp_nz     = dec.jmp_nz;
    assign nop_hit    = dec.nop_hit;
    assign x_sel      = ir[4];
    assign y_sel      = ir[3];
    assign ir_nibble  = ir[3:0];

`ifdef IDU_NOP_CNT_EN
    // Saturating count of consumed NOPs; survives flush
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nop_count <= '0;
        end else if (dec_valid && dec_ready && (|dec.nop_hit) && (nop_count != '1)) begin
            nop_count <= nop_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_instr_decode_unit.sv
// Self-checking bench for instr_decode_unit with a scoreboard of decoded results.
module tb_instr_decode_unit;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        dec_valid;
    logic        dec_ready;
    logic        flush;
    logic [7:0]  ir;
    logic [3:0]  ir_nibble;
    logic [8:0]  reg_en;
    logic [3:0]  source_sel;
    logic        i_sel;
    logic        x_sel;
    logic        y_sel;
    logic        jmp;
    logic        jmp_nz;
    logic [3:0]  nop_hit;
    logic [2:0]  q_level;
`ifdef IDU_NOP_CNT_EN
    logic [CNT_W-1:0] nop_count;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [27:0] exp_q[$];
    logic [27:0] drv_exp;
    logic [27:0] got;

    instr_decode_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .flush       (flush),
        .ir          (ir),
        .ir_nibble   (ir_nibble),
        .reg_en      (reg_en),
        .source_sel  (source_sel),
        .i_sel       (i_sel),
        .x_sel       (x_sel),
        .y_sel       (y_sel),
        .jmp         (jmp),
        .jmp_nz      (jmp_nz),
        .nop_hit     (nop_hit),
        .q_level     (q_level)
`ifdef IDU_NOP_CNT_EN
        ,
        .nop_count   (nop_count)
`endif
    );

    always #5 clk = ~clk;

    assign got = {ir, reg_en, source_sel, i_sel, jmp, jmp_nz, nop_hit};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] pk(input logic [7:0] b, input logic [8:0] re, input logic [3:0] ss,
                                       input logic isel, input logic j, input logic jn, input logic [3:0] nh);
        return {b, re, ss, isel, j, jn, nh};
    endfunction

    // Reference decode of one instruction, written from the instruction-set rules
    function automatic logic [27:0] model(input logic [7:0] b);
        logic [8:0] re;
        logic [3:0] ss;
        logic       isel;
        logic [2:0] d;
        logic [2:0] s;
        re   = 9'h000;
        ss   = 4'd10;
        isel = 1'b1;
        s    = b[2:0];
        d    = b[7] ? b[5:3] : b[6:4];
        if (b[7] == 1'b0 || b[7:6] == 2'b10) begin
            re = (d == 3'd4) ? 9'h100 : (9'h001 << d);
            if (d == 3'd7 || (b[7] && s == 3'd7)) re = re | 9'h040;
            isel = (d != 3'd6);
            if (!b[7])          ss = 4'd8;
            else if (d != s)    ss = {1'b0, s};
            else if (d == 3'd4) ss = 4'd4;
            else                ss = 4'd9;
        end
        if (b[7:5] == 3'b110) re = re | 9'h010;
        return pk(b, re, ss, isel, b[7:4] == 4'hE, b[7:4] == 4'hF,
                  {b == 8'hDF, b == 8'hD8, b == 8'hCF, b == 8'hC8});
    endfunction

    // Scoreboard: pop on consume, push on accepted fetch, drop everything on flush/reset
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            if (dec_valid && dec_ready) begin
                if (exp_q.size() == 0) check("sb_unexpected", 32'(got), 32'hFFFF_FFFF);
                else                   check("dec", 32'(got), 32'(exp_q.pop_front()));
            end
            if (flush)                          exp_q.delete();
            else if (instr_valid && instr_ready) exp_q.push_back(drv_exp);
        end
    end

    task automatic send(input logic [7:0] b, input logic [27:0] e);
        bit ok;
        ok          = 1'b0;
        instr_in    = b;
        drv_exp     = e;
        instr_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (instr_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!ok) check("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        instr_valid = 1'b0;
        dec_ready   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !dec_valid && q_level == 3'd0) break;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check(tag, 32'(got), 32'(pk(8'h00, 9'h000, 4'd10, 1'b1, 1'b0, 1'b0, 4'h0)));
        check({tag, "_lvl"}, {28'd0, q_level, dec_valid}, 32'd0);
`ifdef IDU_NOP_CNT_EN
        check({tag, "_nopcnt"}, 32'(nop_count), 32'd0);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset_n     = 1'b0;
        instr_in    = 8'h00;
        instr_valid = 1'b0;
        dec_ready   = 1'b0;
        flush       = 1'b0;
        drv_exp     = '0;
        #3;
        check_idle("reset");
        check("reset_ready", 32'(instr_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Two-edge latency into an empty queue, then the basic sequence
        dec_ready   = 1'b1;
        instr_in    = 8'h08;
        drv_exp     = pk(8'h08, 9'h001, 4'd8, 1'b1, 1'b0, 1'b0, 4'h0);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        check("lat_k", {28'd0, q_level, dec_valid}, {28'd0, 3'd1, 1'b0});
        @(posedge clk);
        #1;
        check("lat_k1", {28'd0, q_level, dec_valid}, {28'd0, 3'd0, 1'b1});
        send(8'h9A, pk(8'h9A, 9'h008, 4'd2,  1'b1, 1'b0, 1'b0, 4'h0));
        send(8'hC3, pk(8'hC3, 9'h010, 4'd10, 1'b1, 1'b0, 1'b0, 4'h0));
        send(8'hE5, pk(8'hE5, 9'h000, 4'd10, 1'b1, 1'b1, 1'b0, 4'h0));
        drain();

        // Moves, loads to special registers, NOPs and jumps
        send(8'hA4, pk(8'hA4, 9'h100, 4'd4,  1'b1, 1'b0, 1'b0, 4'h0));
        send(8'h9B, pk(8'h9B, 9'h008, 4'd9,  1'b1, 1'b0, 1'b0, 4'h0));
        send(8'hB7, pk(8'hB7, 9'h040, 4'd7,  1'b0, 1'b0, 1'b0, 4'h0));
        send(8'h65, pk(8'h65, 9'h040, 4'd8,  1'b0, 1'b0, 1'b0, 4'h0));
        send(8'h75, pk(8'h75, 9'h0C0, 4'd8,  1'b1, 1'b0, 1'b0, 4'h0));
        send(8'h4A, pk(8'h4A, 9'h100, 4'd8,  1'b1, 1'b0, 1'b0, 4'h0));
        send(8'hC8, pk(8'hC8, 9'h010, 4'd10, 1'b1, 1'b0, 1'b0, 4'h1));
        send(8'hCF, pk(8'hCF, 9'h010, 4'd10, 1'b1, 1'b0, 1'b0, 4'h2));
        send(8'hD8, pk(8'hD8, 9'h010, 4'd10, 1'b1, 1'b0, 1'b0, 4'h4));
        send(8'hDF, pk(8'hDF, 9'h010, 4'd10, 1'b1, 1'b0, 1'b0, 4'h8));
        send(8'hF3, pk(8'hF3, 9'h000, 4'd10, 1'b1, 1'b0, 1'b1, 4'h0));
        send(8'h8E, pk(8'h8E, 9'h002, 4'd6,  1'b1, 1'b0, 1'b0, 4'h0));
        drain();

        // Back-pressure: four in the queue plus one in decode, then release
        dec_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(8'(8'h10 + i), model(8'(8'h10 + i)));
        @(negedge clk);
        check("full_state", {27'd0, instr_ready, q_level, dec_valid}, {27'd0, 1'b0, 3'd4, 1'b1});
        instr_in = 8'h15;
        drv_exp  = model(8'h15);
        repeat (3) @(posedge clk);
        #1;
        check("full_hold", {28'd0, q_level, instr_ready}, {28'd0, 3'd4, 1'b0});
        dec_ready = 1'b1;
        send(8'h15, model(8'h15));
        drain();

        // Flush with three queued entries and a simultaneous push
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(8'h20 + i), model(8'(8'h20 + i)));
        instr_valid = 1'b0;
        check("pre_flush_lvl", 32'(q_level), 32'd3);
        instr_in    = 8'h30;
        drv_exp     = model(8'h30);
        instr_valid = 1'b1;
        flush       = 1'b1;
        @(posedge clk);
        #1;
        flush       = 1'b0;
        instr_valid = 1'b0;
        check("flush_state", {28'd0, q_level, dec_valid}, 32'd0);
        dec_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (dec_valid) seen = 1'b1;
        end
        check("flush_ghost", 32'(seen), 32'd0);

        // Random traffic with random back-pressure and occasional flushes
        for (int i = 0; i < 400; i++) begin
            instr_valid = 1'($urandom_range(0, 1));
            instr_in    = 8'($urandom);
            drv_exp     = model(instr_in);
            dec_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 40) == 0);
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        drain();

`ifdef IDU_NOP_CNT_EN
        // Saturating NOP counter
        for (int i = 0; i < 17; i++) send(8'hC8, pk(8'hC8, 9'h010, 4'd10, 1'b1, 1'b0, 1'b0, 4'h1));
        drain();
        check("nop_sat", 32'(nop_count), 32'h0000_000F);
`endif

        // Asynchronous reset in the middle of a stream
        dec_ready = 1'b0;
        send(8'h11, model(8'h11));
        send(8'h12, model(8'h12));
        send(8'h13, model(8'h13));
        instr_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_idle("midreset");
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        dec_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (dec_valid || q_level != 3'd0) seen = 1'b1;
        end
        check("stale_after_reset", 32'(seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
